// File: rtl/cross_bar_slave_arbiter_if.sv
// Request/grant bundle between the crossbar request decode and one per-slave arbiter.
// The slave modport is the arbiter's view; the master modport drives requests and slave handshakes.
interface cross_bar_slave_arbiter_if #(
    parameter int MASTER_N = 4,
    parameter int MASTER_W = (MASTER_N > 1) ? $clog2(MASTER_N) : 1
);
    logic [MASTER_N-1:0] m_req;
    logic [MASTER_N-1:0] m_cmd;
    logic                s_ack;
    logic                s_resp;
    logic [MASTER_N-1:0] grant;
    logic [MASTER_W-1:0] grant_idx;
    logic                grant_vld;
    logic                timeout;

    modport slave (
        input  m_req, m_cmd, s_ack, s_resp,
        output grant, grant_idx, grant_vld, timeout
    );

    modport master (
        output m_req, m_cmd, s_ack, s_resp,
        input  grant, grant_idx, grant_vld, timeout
    );
endinterface

// File: rtl/cross_bar_slave_arbiter.sv
// Per-slave round-robin arbiter: grants one master and holds it through ack (write) or response (read).
// Optional watchdog abort enabled by defining CROSS_BAR_ARB_TIMEOUT_EN.
module cross_bar_slave_arbiter #(
    parameter int MASTER_N    = 4,
    parameter int MASTER_W    = (MASTER_N > 1) ? $clog2(MASTER_N) : 1,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cross_bar_slave_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

    state_t              state_q, state_d;
    logic [MASTER_N-1:0] grant_q, grant_d;
    logic [MASTER_W-1:0] idx_q, idx_d;
    logic [MASTER_W-1:0] ptr_q, ptr_d;
    logic [MASTER_W-1:0] nxt_ptr;
    logic [MASTER_W:0]   pick_idle, pick_rel;
    logic                release_c;
    logic                expire;

    // Returns {found, index} of the first set request scanning start, start+1, ... with wrap.
    function automatic logic [MASTER_W:0] rr_pick(input logic [MASTER_N-1:0] req,
                                                  input logic [MASTER_W-1:0] start);
        logic [MASTER_W:0] res;
        int                j;
        res = '0;
        for (int i = MASTER_N - 1; i >= 0; i--) begin
            j = int'(start) + i;
            if (j >= MASTER_N) j = j - MASTER_N;
            if (req[j]) res = {1'b1, MASTER_W'(j)};
        end
        return res;
    endfunction

    function automatic logic [MASTER_N-1:0] to_onehot(input logic [MASTER_W-1:0] idx);
        return MASTER_N'(1) << idx;
    endfunction

    assign nxt_ptr   = (idx_q == MASTER_W'(MASTER_N - 1)) ? '0 : idx_q + 1'b1;
    assign pick_idle = rr_pick(bus.m_req, ptr_q);
    assign pick_rel  = rr_pick(bus.m_req & ~grant_q, nxt_ptr);

`ifdef CROSS_BAR_ARB_TIMEOUT_EN
    localparam int CLOG_T = $clog2(TIMEOUT_CYC);
    localparam int CNT_W  = (CLOG_T < 9) ? 9 : ((CLOG_T > 32) ? 32 : CLOG_T);

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q, timeout_d;

    assign expire = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    wire unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        release_c = 1'b0;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_idle[MASTER_W]) begin
                    state_d = ADDR;
                    idx_d   = pick_idle[MASTER_W-1:0];
                    grant_d = to_onehot(pick_idle[MASTER_W-1:0]);
                end
            end
            ADDR: begin
                if (bus.s_ack) begin
                    if (bus.m_cmd[idx_q]) release_c = 1'b1;
                    else                  state_d   = RESP;
                end else if (expire) begin
                    release_c = 1'b1;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
                    timeout_d = 1'b1;
`endif
                end
            end
            RESP: begin
                if (bus.s_resp) begin
                    release_c = 1'b1;
                end else if (expire) begin
                    release_c = 1'b1;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
                    timeout_d = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Released master is masked so a different requester can take over with no bubble.
        if (release_c) begin
            ptr_d = nxt_ptr;
            if (pick_rel[MASTER_W]) begin
                state_d = ADDR;
                idx_d   = pick_rel[MASTER_W-1:0];
                grant_d = to_onehot(pick_rel[MASTER_W-1:0]);
            end else begin
                state_d = IDLE;
                idx_d   = '0;
                grant_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef CROSS_BAR_ARB_TIMEOUT_EN
    // Counter restarts whenever a fresh grant is loaded, including a hand-over at release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
            if (state_d == ADDR && (state_q == IDLE || release_c)) cnt_q <= '0;
            else if (state_q != IDLE)                               cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.grant     = grant_q;
    assign bus.grant_idx = idx_q;
    assign bus.grant_vld = |grant_q;
endmodule
